// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave arbiter for the picorv32 native memory bus with per-transaction timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority (m1 over m0).
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_valid,
    input  logic             m0_instr,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_wstrb,
    output logic             m0_ready,
    output logic [31:0]      m0_rdata,
    input  logic             m1_valid,
    input  logic             m1_instr,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_wstrb,
    input  logic             m1_lock,
    output logic             m1_ready,
    output logic [31:0]      m1_rdata,
    output logic             s_valid,
    output logic             s_instr,
    output logic [31:0]      s_addr,
    output logic [31:0]      s_wdata,
    output logic [3:0]       s_wstrb,
    input  logic             s_ready,
    input  logic [31:0]      s_rdata,
    output logic             owner,
    output logic             timeout_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clr
);

    typedef enum logic {StIdle, StBusy} state_t;

    localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 1;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [31:0]      timer_q, timer_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_valid;
    logic             grant;
    logic             done;
    logic             tmo;
    logic             tmo_hit;
    logic             hold;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // On contention the master that lost the previous arbitration wins.
    always_comb begin
        if (m0_valid && m1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = m1_valid;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == StIdle && (m0_valid || m1_valid)) begin
            last_grant_d = grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign grant = m1_valid;
`endif

    assign sel_valid = owner_q ? m1_valid : m0_valid;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (timer_q == TMO_LAST);
    assign hold      = owner_q && m1_lock;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        timer_d  = timer_q;
        done     = 1'b0;
        tmo      = 1'b0;
        s_valid  = 1'b0;
        s_instr  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;

        case (state_q)
            StIdle: begin
                if (m0_valid || m1_valid) begin
                    owner_d = grant;
                    timer_d = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                s_instr = owner_q ? m1_instr : m0_instr;
                s_addr  = owner_q ? m1_addr  : m0_addr;
                s_wdata = owner_q ? m1_wdata : m0_wdata;
                s_wstrb = owner_q ? m1_wstrb : m0_wstrb;

                if (!sel_valid) begin
                    // Lock hold waits for the next m1 request; otherwise the owner abandoned it.
                    if (!hold) begin
                        state_d = StIdle;
                    end
                end else if (s_ready) begin
                    done    = 1'b1;
                    timer_d = '0;
                    if (!hold) begin
                        state_d = StIdle;
                    end
                end else if (tmo_hit) begin
                    tmo     = 1'b1;
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 32'd1;
                end

                s_valid  = sel_valid && !tmo;
                m0_ready = (done || tmo) && !owner_q;
                m1_ready = (done || tmo) && owner_q;
                m0_rdata = tmo ? ERR_RDATA : s_rdata;
                m1_rdata = tmo ? ERR_RDATA : s_rdata;
            end
            default: state_d = StIdle;
        endcase
    end

    // err_clr takes precedence over a timeout in the same cycle.
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (err_clr) begin
            err_d = 1'b0;
            cnt_d = '0;
        end else if (tmo) begin
            err_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            timer_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign owner       = owner_q;
    assign timeout_err = err_q;
    assign err_count   = cnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (fixed-priority build, TIMEOUT_CYCLES = 8).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_lock, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        owner, timeout_err, err_clr;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA     (32'hDEAD_BEEF),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_valid   (m0_valid),
        .m0_instr   (m0_instr),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_ready   (m0_ready),
        .m0_rdata   (m0_rdata),
        .m1_valid   (m1_valid),
        .m1_instr   (m1_instr),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_lock    (m1_lock),
        .m1_ready   (m1_ready),
        .m1_rdata   (m1_rdata),
        .s_valid    (s_valid),
        .s_instr    (s_instr),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .owner      (owner),
        .timeout_err(timeout_err),
        .err_count  (err_count),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0; m1_lock = 0;
        s_ready = 0; s_rdata = 0; err_clr = 0;

        // Reset state
        tick; tick; #1;
        chk("rst_s_valid", {31'b0, s_valid}, 0);
        chk("rst_m0_ready", {31'b0, m0_ready}, 0);
        chk("rst_m1_ready", {31'b0, m1_ready}, 0);
        chk("rst_owner", {31'b0, owner}, 0);
        chk("rst_err", {31'b0, timeout_err}, 0);
        chk("rst_cnt", {16'b0, err_count}, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_m0_rdata", m0_rdata, 0);

        // Single CPU read, slave ready two cycles after s_valid
        tick; reset = 0;
        tick; m0_valid = 1; m0_addr = 32'h0000_0010; #1;
        chk("t1_idle_s_valid", {31'b0, s_valid}, 0);
        tick; #1;
        chk("t1_b1_s_valid", {31'b0, s_valid}, 1);
        chk("t1_b1_s_addr", s_addr, 32'h0000_0010);
        chk("t1_b1_owner", {31'b0, owner}, 0);
        chk("t1_b1_m0_ready", {31'b0, m0_ready}, 0);
        tick; #1;
        chk("t1_b2_m0_ready", {31'b0, m0_ready}, 0);
        tick; s_ready = 1; s_rdata = 32'h1234_5678; #1;
        chk("t1_m0_ready", {31'b0, m0_ready}, 1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m1_ready", {31'b0, m1_ready}, 0);
        tick; m0_valid = 0; s_ready = 0; #1;
        chk("t1_after_m0_ready", {31'b0, m0_ready}, 0);
        chk("t1_after_s_valid", {31'b0, s_valid}, 0);

        // Contention: m1 first, then m0 after one idle cycle
        tick; m0_valid = 1; m0_addr = 32'h100; m1_valid = 1; m1_addr = 32'h200; #1;
        chk("t2_idle_s_valid", {31'b0, s_valid}, 0);
        tick; s_ready = 1; s_rdata = 32'h0000_00A1; #1;
        chk("t2_owner_m1", {31'b0, owner}, 1);
        chk("t2_s_addr_m1", s_addr, 32'h200);
        chk("t2_m1_ready", {31'b0, m1_ready}, 1);
        chk("t2_m1_rdata", m1_rdata, 32'h0000_00A1);
        chk("t2_m0_ready_0", {31'b0, m0_ready}, 0);
        tick; m1_valid = 0; s_ready = 0; #1;
        chk("t2_gap_s_valid", {31'b0, s_valid}, 0);
        tick; s_ready = 1; s_rdata = 32'h0000_00B2; #1;
        chk("t2_owner_m0", {31'b0, owner}, 0);
        chk("t2_s_addr_m0", s_addr, 32'h100);
        chk("t2_m0_ready", {31'b0, m0_ready}, 1);
        chk("t2_m1_ready_0", {31'b0, m1_ready}, 0);
        tick; m0_valid = 0; s_ready = 0;

        // Locked burst of three m1 writes while m0 waits
        tick; m0_valid = 1; m0_addr = 32'h300;
        m1_lock = 1; m1_valid = 1; m1_addr = 32'h400; m1_wdata = 32'hA0; m1_wstrb = 4'hF;
        tick;
        for (int i = 0; i < 3; i++) begin
            m1_addr = 32'h400 + 32'(4 * i); m1_wdata = 32'hA0 + 32'(i); s_ready = 1; #1;
            chk("t3_s_valid", {31'b0, s_valid}, 1);
            chk("t3_s_addr", s_addr, 32'h400 + 32'(4 * i));
            chk("t3_s_wdata", s_wdata, 32'hA0 + 32'(i));
            chk("t3_s_wstrb", {28'b0, s_wstrb}, 32'hF);
            chk("t3_m1_ready", {31'b0, m1_ready}, 1);
            chk("t3_m0_ready", {31'b0, m0_ready}, 0);
            tick;
        end
        m1_valid = 0; s_ready = 0; #1;
        chk("t3_hold_s_valid", {31'b0, s_valid}, 0);
        chk("t3_hold_owner", {31'b0, owner}, 1);
        tick; #1;
        chk("t3_hold2_owner", {31'b0, owner}, 1);
        chk("t3_hold2_s_valid", {31'b0, s_valid}, 0);
        tick; m1_lock = 0; #1;
        chk("t3_drop_s_valid", {31'b0, s_valid}, 0);
        tick; #1;
        chk("t3_idle_s_valid", {31'b0, s_valid}, 0);
        chk("t3_idle_owner", {31'b0, owner}, 1);
        tick; s_ready = 1; #1;
        chk("t3_m0_owner", {31'b0, owner}, 0);
        chk("t3_m0_addr", s_addr, 32'h300);
        chk("t3_m0_ready", {31'b0, m0_ready}, 1);
        tick; m0_valid = 0; s_ready = 0;

        // Timeout after 8 BUSY cycles, then err_clr
        tick; m0_valid = 1; m0_addr = 32'hF000_0000; s_rdata = 32'h5555_5555;
        for (int i = 1; i <= 7; i++) begin
            tick; #1;
            chk("t4_wait_s_valid", {31'b0, s_valid}, 1);
            chk("t4_wait_m0_ready", {31'b0, m0_ready}, 0);
        end
        tick; #1;
        chk("t4_tmo_m0_ready", {31'b0, m0_ready}, 1);
        chk("t4_tmo_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t4_tmo_s_valid", {31'b0, s_valid}, 0);
        tick; m0_valid = 0; #1;
        chk("t4_err", {31'b0, timeout_err}, 1);
        chk("t4_cnt", {16'b0, err_count}, 1);
        chk("t4_after_ready", {31'b0, m0_ready}, 0);
        tick; err_clr = 1;
        tick; err_clr = 0; #1;
        chk("t4_clr_err", {31'b0, timeout_err}, 0);
        chk("t4_clr_cnt", {16'b0, err_count}, 0);

        // Asynchronous reset while BUSY
        tick; m1_valid = 1; m1_addr = 32'h20;
        tick; #1;
        chk("t5_busy_s_valid", {31'b0, s_valid}, 1);
        chk("t5_busy_owner", {31'b0, owner}, 1);
        #2; reset = 1; #1;
        chk("t5_rst_s_valid", {31'b0, s_valid}, 0);
        chk("t5_rst_m1_ready", {31'b0, m1_ready}, 0);
        chk("t5_rst_owner", {31'b0, owner}, 0);
        tick; #1;
        chk("t5_rst2_m1_ready", {31'b0, m1_ready}, 0);
        reset = 0; m1_valid = 0; m0_valid = 1; m0_addr = 32'h30;
        tick; s_ready = 1; s_rdata = 32'h0000_CAFE; #1;
        chk("t5_post_owner", {31'b0, owner}, 0);
        chk("t5_post_m0_ready", {31'b0, m0_ready}, 1);
        chk("t5_post_rdata", m0_rdata, 32'h0000_CAFE);
        tick; m0_valid = 0; s_ready = 0;

        // Owner abandons the request mid-transaction
        tick; m0_valid = 1; m0_addr = 32'h40;
        tick; #1;
        chk("t6_busy_s_valid", {31'b0, s_valid}, 1);
        tick; m0_valid = 0; #1;
        chk("t6_drop_s_valid", {31'b0, s_valid}, 0);
        chk("t6_drop_m0_ready", {31'b0, m0_ready}, 0);
        tick; m0_valid = 1; #1;
        chk("t6_idle_s_valid", {31'b0, s_valid}, 0);
        chk("t6_cnt", {16'b0, err_count}, 0);
        chk("t6_err", {31'b0, timeout_err}, 0);
        tick; s_ready = 1; s_rdata = 32'h0000_0042; #1;
        chk("t6_retry_m0_ready", {31'b0, m0_ready}, 1);
        chk("t6_retry_rdata", m0_rdata, 32'h0000_0042);
        tick; m0_valid = 0; s_ready = 0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the picorv32 native memory bus (valid/ready, addr, wdata, wstrb, instr, rdata).
- Shares the on-chip RAM and UART register decode between the CPU (master 0) and a host debug/loader engine (master 1), which pokes or peeks memory while the CPU is stopped or running.
- Sits between the masters and the existing address decode / mem_ready mux.
- Adds a per-transaction timeout so a hung slave (e.g. an unmapped address) cannot wedge the bus.

Parameters:
- TIMEOUT_CYCLES, 1024: slave cycles allowed before a forced error completion; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transaction.
- CNT_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_valid  in  1  CPU request.
- m0_instr  in  1  CPU instruction-fetch flag.
- m0_addr  in  32  CPU address.
- m0_wdata  in  32  CPU write data.
- m0_wstrb  in  4  CPU byte strobes; 0 means read.
- m0_ready  out  1  CPU completion pulse.
- m0_rdata  out  32  CPU read data.
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb  in  1/1/32/32/4  debug master request; same meanings as m0.
- m1_lock  in  1  debug master keeps ownership between back-to-back transactions.
- m1_ready  out  1  debug completion pulse.
- m1_rdata  out  32  debug read data.
- s_valid  out  1  slave request.
- s_instr  out  1  slave instruction-fetch flag.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_wstrb  out  4  slave byte strobes.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- owner  out  1  current/last grant: 0 = CPU, 1 = debug.
- timeout_err  out  1  sticky; set on any timeout.
- err_count  out  CNT_W  number of timeouts, saturating.
- err_clr  in  1  synchronous clear of timeout_err and err_count.

Behaviour:
- FSM states: IDLE, BUSY.
  - owner is a register.
  - Timer counts slave cycles in BUSY.
- Reset values:
  - State IDLE, owner 0, timer 0, timeout_err 0, err_count 0.
  - All ready outputs and s_valid are 0; rdata and s_* payload outputs are 0.
  - Reset asserted mid-transaction aborts immediately; no ready is issued.
- Arbitration in IDLE (fixed priority, see Optional Feature):
  - m1_valid beats m0_valid.
  - On any valid, owner is loaded and the state goes to BUSY at the next edge.
  - Grant latency is 1 cycle; no slave access occurs in the IDLE cycle.
- BUSY datapath:
  - s_valid = selected mX_valid. s_instr, s_addr, s_wdata and s_wstrb are muxed combinationally from the owner.
  - mX_ready = s_ready & (owner == X); s_rdata passes to both mX_rdata outputs.
  - The non-owner's ready is always 0.
- Completion, when s_ready is sampled high in BUSY:
  - The owner sees a 1-cycle ready.
  - The state returns to IDLE, so one idle cycle follows each transaction and gives the other master a chance at the bus.
  - If owner == 1 and m1_lock == 1, the state stays BUSY and owner stays 1; the next m1 request starts without an IDLE cycle.
- Lock release: if m1_lock is high and m1_valid is low in BUSY, the arbiter keeps ownership. s_valid stays 0 until m1 requests again or m1_lock drops; a lock drop returns the state to IDLE at the next edge.
- Owner drops valid before ready (protocol violation): s_valid follows to 0 the same cycle and the state returns to IDLE at the next edge. This is not counted as an error.
- Timeout:
  - The timer clears on entry to BUSY and on each completion, and increments each BUSY cycle with s_valid high and s_ready low.
  - When the timer reaches TIMEOUT_CYCLES-1 with s_ready still low:
    - The owner gets a ready pulse with rdata = ERR_RDATA, and s_valid is forced low that cycle.
    - timeout_err sets, err_count increments (saturating at all-ones), and the state returns to IDLE.
  - If s_ready and the timeout coincide, the transaction is a normal completion.
- err_clr wins over a same-cycle timeout increment: both timeout_err and err_count are left at 0.
- Bus hold: the CPU holds the bus between its own transactions only by re-requesting in IDLE.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration in IDLE. When both masters request, the grant goes to the master that did not win the previous arbitration, which is tracked by a last_grant register (reset 0, so m1 wins first). m1_lock is still honoured.
- MEM_ARB_RR_EN undefined: fixed priority, m1 over m0; no last_grant register.

Test Plan:
- Single CPU read, addr 0x0000_0010, s_ready 2 cycles after s_valid, s_rdata 0x1234_5678 -> m0_ready pulse 1 cycle with m0_rdata 0x1234_5678, m1_ready stays 0, owner 0.
- Both valid in the same IDLE cycle, fixed priority -> m1 served first, then m0 after one IDLE cycle; with MEM_ARB_RR_EN, alternation m1, m0, m1, m0 over 4 contended requests.
- m1_lock high, m1 issues 3 writes (wstrb 4'hF) back-to-back while m0_valid held high -> all 3 complete with no IDLE gap, m0 granted only after lock drops.
- TIMEOUT_CYCLES 8, s_ready held 0 -> owner ready at the 8th BUSY cycle with rdata 0xDEAD_BEEF, timeout_err 1, err_count 1; err_clr -> both 0.
- Reset asserted while BUSY with s_ready low -> s_valid, ready and owner 0 immediately, no ready pulse; the next request is served normally.
- m0 drops valid mid-transaction -> s_valid 0 the same cycle, IDLE next cycle, err_count unchanged.
